// File: rtl/uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_pkg
// Shared UART definitions, also used by uart_rx: the 3-bit state encoding,
// the default bit period for 115200 baud at 25 MHz, the data width, and the
// parity helper.
// Optional build macro used by uart_tx: UART_TX_PARITY_EN.
// ----------------------------------------------------------------------------
package uart_tx_pkg;

   localparam int DATA_W               = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 217;
   localparam int CNT_W                = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Parity bit for a byte: XOR of all data bits, inverted for odd parity.
   function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                       input logic              odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_tx_baud_gen
// Bit-period counter. It counts 0..CLKS_PER_BIT-1 while enabled and wraps
// to 0. It also serves uart_rx for its full- and half-period ticks.
//   i_clk25MHz   clock
//   i_reset      asynchronous active-high reset
//   i_en         count enable
//   i_clr        synchronous clear; takes priority over i_en
//   o_tick       registered; high during the cycle in which the count is
//                CLKS_PER_BIT-1, which is the last cycle of a bit
//   o_tick_next  combinational; o_tick will be high in the next cycle
// ----------------------------------------------------------------------------
module uart_tx_baud_gen
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)(
   input  logic i_clk25MHz,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick,
   output logic o_tick_next
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             tick_r;

   // Next count: clear, wrap at the last cycle of the bit, or advance.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (i_clr) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (i_en) begin
         if (cnt_r == LAST) begin
            cnt_nxt_s = {CNT_W{1'b0}};
         end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // The tick is registered from the next count so it needs no decode after the flop.
   always_ff @(posedge i_clk25MHz or posedge i_reset) begin
      if (i_reset) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == LAST);
      end
   end

   assign o_tick      = tick_r;
   assign o_tick_next = (cnt_nxt_s == LAST);

endmodule

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter. It accepts one byte per valid/ready handshake and
// sends it LSB-first: a start bit, 8 data bits and a stop bit. There is no
// internal queue.
// Optional build macro UART_TX_PARITY_EN inserts a parity bit between the
// data and stop bits. The parity is even when PARITY_ODD=0 and odd when
// PARITY_ODD=1.
//   i_clk25MHz  25 MHz clock
//   i_reset     asynchronous active-high reset; abandons any frame in flight
//   i_valid     i_data holds a byte to send
//   i_data      byte; latched when the handshake completes
//   o_ready     idle and able to accept a byte
//   o_busy      frame in progress (~o_ready)
//   o_done      one-cycle pulse on the last cycle of the stop bit
//   o_tx        serial line, idles high, driven from a flop
// All outputs are registered. Each is computed from the next state, so
// o_tx changes on the same edge as the state.
// ----------------------------------------------------------------------------
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_ODD   = 0
)(
   input  logic              i_clk25MHz,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_tx
);

   // Stop elaboration if a parameter is out of range.
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_tx: CLKS_PER_BIT must be 2..65535 and PARITY_ODD 0 or 1");
   end

   uart_state_e       state_r;
   uart_state_e       state_nxt_s;
   logic [DATA_W-1:0] shift_r;
   logic [DATA_W-1:0] shift_nxt_s;
   logic [2:0]        bit_cnt_r;
   logic [2:0]        bit_cnt_nxt_s;
   logic              tx_r;
   logic              tx_nxt_s;
   logic              ready_r;
   logic              busy_r;
   logic              done_r;
   logic              done_nxt_s;
   logic              accept_s;
   logic              baud_en_s;
   logic              tick_s;
   logic              tick_next_s;
`ifdef UART_TX_PARITY_EN
   logic              parity_r;
   logic              parity_nxt_s;
`endif

   assign accept_s  = i_valid && ready_r;
   assign baud_en_s = (state_r != ST_IDLE);

   uart_tx_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .i_clk25MHz  (i_clk25MHz),
      .i_reset     (i_reset),
      .i_en        (baud_en_s),
      .i_clr       (accept_s),
      .o_tick      (tick_s),
      .o_tick_next (tick_next_s)
   );

   // Next-state logic: sequence through the frame one bit period at a time.
   always_comb begin
      state_nxt_s   = state_r;
      shift_nxt_s   = shift_r;
      bit_cnt_nxt_s = bit_cnt_r;
`ifdef UART_TX_PARITY_EN
      parity_nxt_s  = parity_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s   = ST_START;
               shift_nxt_s   = i_data;
               bit_cnt_nxt_s = 3'd0;
`ifdef UART_TX_PARITY_EN
               parity_nxt_s  = parity_bit(i_data, 1'(PARITY_ODD));
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_nxt_s = {1'b0, shift_r[DATA_W-1:1]};
               if (bit_cnt_r == 3'd7) begin
                  bit_cnt_nxt_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_nxt_s   = ST_PARITY;
`else
                  state_nxt_s   = ST_STOP;
`endif
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + 3'd1;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick_s) begin
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (tick_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Line level for the coming cycle, taken from the next state and shifter.
   always_comb begin
      tx_nxt_s = 1'b1;
      case (state_nxt_s)
         ST_IDLE:   tx_nxt_s = 1'b1;
         ST_START:  tx_nxt_s = 1'b0;
         ST_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_nxt_s = parity_nxt_s;
`endif
         ST_STOP:   tx_nxt_s = 1'b1;
         default:   tx_nxt_s = 1'b1;
      endcase
   end

   // o_done marks the cycle that the baud counter ends inside STOP.
   assign done_nxt_s = (state_nxt_s == ST_STOP) && tick_next_s;

   // State, datapath and output flops.
   always_ff @(posedge i_clk25MHz or posedge i_reset) begin
      if (i_reset) begin
         state_r   <= ST_IDLE;
         shift_r   <= {DATA_W{1'b0}};
         bit_cnt_r <= 3'd0;
         tx_r      <= 1'b1;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         shift_r   <= shift_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         tx_r      <= tx_nxt_s;
         ready_r   <= (state_nxt_s == ST_IDLE);
         busy_r    <= (state_nxt_s != ST_IDLE);
         done_r    <= done_nxt_s;
      end
   end

`ifdef UART_TX_PARITY_EN
   // Parity of the byte latched at acceptance.
   always_ff @(posedge i_clk25MHz or posedge i_reset) begin
      if (i_reset) begin
         parity_r <= 1'b0;
      end else begin
         parity_r <= parity_nxt_s;
      end
   end
`endif

   assign o_tx    = tx_r;
   assign o_ready = ready_r;
   assign o_busy  = busy_r;
   assign o_done  = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
// Scoreboard bench for uart_tx. The stimulus pushes the expected frame as
// a bit vector built with arithmetic, plus the acceptance cycle. A monitor
// finds each start bit on o_tx and compares the whole line against that
// vector. It also checks the o_done position and o_ready around the frame.
// ----------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB        = 217;
   localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       ready;
   logic       busy;
   logic       done;
   logic       tx;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .PARITY_ODD   (PARITY_ODD)
   ) dut (
      .i_clk25MHz (clk),
      .i_reset    (rst),
      .i_valid    (valid),
      .i_data     (data),
      .o_ready    (ready),
      .o_busy     (busy),
      .o_done     (done),
      .o_tx       (tx)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] bits;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   start_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h) cycle=%0d",
                  name, act, act, expv, expv, cyc);
      end
   endtask

   // Line levels of a frame, LSB first: start 0, data, [parity], stop 1.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic [10:0] f;
      f = 11'(d) << 1;
`ifdef UART_TX_PARITY_EN
      f = f | (11'(($countones(d) + PARITY_ODD) % 2) << 9) | (11'd1 << 10);
`else
      f = f | (11'd1 << 9);
`endif
      return f;
   endfunction

   task automatic push_exp(input logic [7:0] d);
      exp_t e;
      e.data = d;
      e.bits = frame_of(d);
      e.acc  = cyc;
      exp_q.push_back(e);
   endtask

   // Called at a negedge. The byte is accepted at the next posedge on which o_ready is high.
   task automatic send(input logic [7:0] d, input bit hold);
      int w;
      valid = 1'b1;
      data  = d;
      w     = 0;
      while (ready !== 1'b1 && w < 3 * FRAME) begin
         @(negedge clk);
         w++;
      end
      check("send_accept", int'(ready), 1);
      if (ready === 1'b1) begin
         push_exp(d);
         @(negedge clk);
      end
      if (!hold) valid = 1'b0;
      data = 8'($urandom);
   endtask

   // Invariant: o_busy is the complement of o_ready.
   initial begin : busy_mon
      forever begin
         @(negedge clk);
         check("busy_not_ready", int'(busy), int'(!ready));
      end
   end

   // Frame monitor: pops an expected frame when a start bit appears.
   initial begin : frame_mon
      exp_t       e;
      int         st;
      bit         aborted;
      int         bad_off;
      int         done_cnt;
      int         done_at;
      int         ready_hi;
      logic [7:0] got;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || tx !== 1'b0) continue;
         st = cyc;
         start_q.push_back(st);
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            e.data = 8'h00;
            e.bits = frame_of(8'h00);
            e.acc  = st - 1;
         end else begin
            e = exp_q.pop_front();
         end
         check("start_latency", st - e.acc, 1);
         aborted  = 1'b0;
         bad_off  = -1;
         done_cnt = 0;
         done_at  = -1;
         ready_hi = 0;
         got      = 8'h00;
         for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            if (rst === 1'b1) begin
               aborted = 1'b1;
               break;
            end
            if (tx !== e.bits[j / CPB] && bad_off < 0) bad_off = j;
            if ((j % CPB) == (CPB / 2) && (j / CPB) >= 1 && (j / CPB) <= 8)
               got[(j / CPB) - 1] = tx;
            if (done === 1'b1) begin
               done_cnt++;
               done_at = cyc - e.acc;
            end
            if (ready !== 1'b0) ready_hi++;
         end
         if (aborted) begin
            check("abort_tx_high", int'(tx), 1);
            check("abort_no_done", int'(done), 0);
         end else begin
            check("line_first_bad_offset", bad_off, -1);
            check("data_at_centres", int'(got), int'(e.data));
            check("done_count", done_cnt, 1);
            check("done_after_accept", done_at, FRAME);
            check("ready_low_in_frame", ready_hi, 0);
            @(negedge clk);
            check("ready_after_done", int'(ready), 1);
            check("idle_line_high", int'(tx), 1);
         end
      end
   end

   initial begin : stim
      logic [7:0] d;
      bit         hold;
      repeat (3) @(negedge clk);
      check("rst_tx", int'(tx), 1);
      check("rst_ready", int'(ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      #2 rst = 1'b0;
      @(negedge clk);

      // Alternating bits.
      send(8'h55, 1'b0);
      repeat (FRAME + 4) @(negedge clk);

      // Back-to-back frames with i_valid held.
      send(8'h00, 1'b1);
      send(8'hFF, 1'b0);
      repeat (FRAME + 4) @(negedge clk);
      check("b2b_start_spacing", start_q[$] - start_q[$-1], FRAME + 1);

      // Request while busy is ignored.
      send(8'h12, 1'b0);
      repeat (3 * CPB) @(negedge clk);
      check("ready_low_while_busy", int'(ready), 0);
      valid = 1'b1;
      data  = 8'h3C;
      @(negedge clk);
      valid = 1'b0;
      repeat (FRAME) @(negedge clk);

      // Reset in the middle of data bit 4 of 0xA5, then 0x81 requested through the reset.
      send(8'hA5, 1'b0);
      repeat (5 * CPB + CPB / 2) @(negedge clk);
      check("pre_reset_bit4_low", int'(tx), 0);
      #2 rst = 1'b1;
      valid = 1'b1;
      data  = 8'h81;
      #1;
      check("async_reset_tx", int'(tx), 1);
      check("async_reset_ready", int'(ready), 1);
      check("async_reset_done", int'(done), 0);
      repeat (3) @(negedge clk);
      check("no_accept_in_reset", int'(tx), 1);
      #2 rst = 1'b0;
      push_exp(8'h81);
      @(negedge clk);
      valid = 1'b0;
      repeat (FRAME + 4) @(negedge clk);

      // Random bytes, gaps and holds, with stray requests while busy.
      for (int k = 0; k < 8; k++) begin
         d    = 8'($urandom);
         hold = (k == 7) ? 1'b0 : 1'($urandom_range(0, 1));
         send(d, hold);
         if (!hold) begin
            repeat ($urandom_range(1, 3 * CPB)) @(negedge clk);
            if (ready === 1'b0) begin
               valid = 1'b1;
               data  = 8'($urandom);
               @(negedge clk);
               valid = 1'b0;
            end
         end
      end
      repeat (FRAME + 10) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
